// File: rtl/spi_command_receiver.sv
// SPI-slave command front end: oversamples SCK/CS/DI, assembles bytes MSB first
// and parses 48-bit SD-style command frames (start, cmd, 32-bit arg, CRC7, end bit).
module spi_command_receiver (
    input  logic        clock,
    input  logic        reset,
    input  logic        io_SCK,
    input  logic        io_CS,
    input  logic        io_DI,
    output logic [7:0]  io_Buffer,
    output logic        io_BufferChange,
    output logic [5:0]  io_Command,
    output logic [31:0] io_CommandArgument,
    output logic        io_CommandReadFinished,
    output logic        io_ArgumentReadFinished,
    output logic        io_ReadSuccess,
    output logic [2:0]  io____state
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ARG  = 3'd1,
        CRC  = 3'd2
    } state_t;

    state_t      state;
    state_t      state_next;

    logic        sck_s1, sck_s2, sck_prev;
    logic        cs_s1, cs_s2;
    logic        di_s1, di_s2;
    logic        sck_rise;

    logic [7:0]  buffer;
    logic [2:0]  bit_cnt;
    logic        byte_done;

    logic [5:0]  command;
    logic [31:0] argument;
    logic        cmd_done;
    logic        arg_done;
    logic        read_ok;
    logic [6:0]  crc;
    logic [1:0]  byte_cnt;

    // CRC7 (x^7 + x^3 + 1) advanced over one byte, MSB first.
    function automatic logic [6:0] crc7_byte(input logic [6:0] crc_in, input logic [7:0] data);
        logic [6:0] c;
        logic       fb;
        c = crc_in;
        for (int i = 7; i >= 0; i--) begin
            fb = c[6] ^ data[i];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            sck_s1   <= 1'b0;
            sck_s2   <= 1'b0;
            sck_prev <= 1'b0;
            cs_s1    <= 1'b1;
            cs_s2    <= 1'b1;
            di_s1    <= 1'b1;
            di_s2    <= 1'b1;
        end else begin
            sck_s1   <= io_SCK;
            sck_s2   <= sck_s1;
            sck_prev <= sck_s2;
            cs_s1    <= io_CS;
            cs_s2    <= cs_s1;
            di_s1    <= io_DI;
            di_s2    <= di_s1;
        end
    end

    assign sck_rise = sck_s2 & ~sck_prev;

    always_ff @(posedge clock) begin
        if (reset) begin
            buffer    <= 8'h00;
            bit_cnt   <= 3'd0;
            byte_done <= 1'b0;
        end else begin
            byte_done <= 1'b0;
            if (cs_s2) begin
                bit_cnt <= 3'd0;
            end else if (sck_rise) begin
                buffer  <= {buffer[6:0], di_s2};
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) byte_done <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (cs_s2) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: if (byte_done && buffer[7:6] == 2'b01) state_next = ARG;
                ARG:  if (byte_done && byte_cnt == 2'd3)     state_next = CRC;
                CRC:  if (byte_done)                         state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Frame fields update one cycle after the byte pulse, alongside the state change.
    always_ff @(posedge clock) begin
        if (reset) begin
            command  <= 6'd0;
            argument <= 32'd0;
            cmd_done <= 1'b0;
            arg_done <= 1'b0;
            read_ok  <= 1'b0;
            crc      <= 7'd0;
            byte_cnt <= 2'd0;
        end else if (!cs_s2 && byte_done) begin
            case (state)
                IDLE: begin
                    if (buffer[7:6] == 2'b01) begin
                        command  <= buffer[5:0];
                        argument <= 32'd0;
                        cmd_done <= 1'b1;
                        arg_done <= 1'b0;
                        read_ok  <= 1'b0;
                        byte_cnt <= 2'd0;
                        crc      <= crc7_byte(7'd0, buffer);
                    end
                end
                ARG: begin
                    argument <= {argument[23:0], buffer};
                    crc      <= crc7_byte(crc, buffer);
                    byte_cnt <= byte_cnt + 2'd1;
                    if (byte_cnt == 2'd3) arg_done <= 1'b1;
                end
                CRC: begin
                    read_ok <= (buffer[7:1] == crc) && buffer[0];
                end
                default: begin
                end
            endcase
        end
    end

    assign io_Buffer               = buffer;
    assign io_BufferChange         = byte_done;
    assign io_Command              = command;
    assign io_CommandArgument      = argument;
    assign io_CommandReadFinished  = cmd_done;
    assign io_ArgumentReadFinished = arg_done;
    assign io_ReadSuccess          = read_ok;
    assign io____state             = state;

endmodule

// File: tb/tb_spi_command_receiver.sv
// Bench for spi_command_receiver: directed SD command frames plus randomized
// frames, filler, aborts and SCK timing, compared against a frame-level model.
module tb_spi_command_receiver;

    logic        clock = 1'b0;
    logic        reset;
    logic        io_SCK, io_CS, io_DI;
    logic [7:0]  io_Buffer;
    logic        io_BufferChange;
    logic [5:0]  io_Command;
    logic [31:0] io_CommandArgument;
    logic        io_CommandReadFinished, io_ArgumentReadFinished, io_ReadSuccess;
    logic [2:0]  io____state;

    spi_command_receiver dut (
        .clock                   (clock),
        .reset                   (reset),
        .io_SCK                  (io_SCK),
        .io_CS                   (io_CS),
        .io_DI                   (io_DI),
        .io_Buffer               (io_Buffer),
        .io_BufferChange         (io_BufferChange),
        .io_Command              (io_Command),
        .io_CommandArgument      (io_CommandArgument),
        .io_CommandReadFinished  (io_CommandReadFinished),
        .io_ArgumentReadFinished (io_ArgumentReadFinished),
        .io_ReadSuccess          (io_ReadSuccess),
        .io____state             (io____state)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic [7:0]  exp_buf;
    int          exp_bits;
    int          exp_pulses = 0;
    logic [5:0]  exp_cmd;
    logic [31:0] exp_arg;
    logic        exp_cmd_done, exp_arg_done, exp_ok;
    logic [7:0]  frame_q[$];

    // BufferChange observation
    int   pulse_cnt = 0;
    int   wide_cnt  = 0;
    logic bc_prev   = 1'b0;

    always @(negedge clock) begin
        if (io_BufferChange) begin
            pulse_cnt++;
            if (bc_prev) wide_cnt++;
        end
        bc_prev = io_BufferChange;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // CRC7 as polynomial remainder of message * x^7 modulo x^7+x^3+1.
    function automatic logic [6:0] crc_ref(input logic [39:0] msg);
        logic [46:0] r;
        r = {msg, 7'd0};
        for (int i = 46; i >= 7; i--)
            if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
        return r[6:0];
    endfunction

    function automatic logic [2:0] exp_state();
        if (frame_q.size() == 0) return 3'd0;
        if (frame_q.size() <= 4) return 3'd1;
        return 3'd2;
    endfunction

    task automatic model_reset();
        exp_buf = 8'h00; exp_bits = 0;
        exp_cmd = 6'd0; exp_arg = 32'd0;
        exp_cmd_done = 1'b0; exp_arg_done = 1'b0; exp_ok = 1'b0;
        frame_q.delete();
    endtask

    task automatic model_byte(input logic [7:0] b);
        logic [39:0] msg;
        if (frame_q.size() == 0) begin
            if (b[7:6] == 2'b01) begin
                frame_q.push_back(b);
                exp_cmd = b[5:0]; exp_arg = 32'd0;
                exp_cmd_done = 1'b1; exp_arg_done = 1'b0; exp_ok = 1'b0;
            end
        end else if (frame_q.size() < 5) begin
            frame_q.push_back(b);
            exp_arg = {exp_arg[23:0], b};
            if (frame_q.size() == 5) exp_arg_done = 1'b1;
        end else begin
            msg = {frame_q[0], frame_q[1], frame_q[2], frame_q[3], frame_q[4]};
            exp_ok = (b[7:1] == crc_ref(msg)) && b[0];
            frame_q.delete();
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic send_bit(input logic b);
        io_DI  = b;
        io_SCK = 1'b0;
        wait_cyc($urandom_range(2, 4));
        io_SCK = 1'b1;
        wait_cyc($urandom_range(2, 4));
        io_SCK = 1'b0;
        if (!io_CS) begin
            exp_buf = {exp_buf[6:0], b};
            exp_bits++;
            if (exp_bits == 8) begin
                exp_bits = 0;
                exp_pulses++;
                model_byte(exp_buf);
            end
        end
    endtask

    task automatic check_outputs(input string ctx);
        check({ctx, ".buffer"},     {24'd0, io_Buffer},                exp_buf);
        check({ctx, ".command"},    {26'd0, io_Command},               {26'd0, exp_cmd});
        check({ctx, ".argument"},   io_CommandArgument,                exp_arg);
        check({ctx, ".cmd_done"},   {31'd0, io_CommandReadFinished},   {31'd0, exp_cmd_done});
        check({ctx, ".arg_done"},   {31'd0, io_ArgumentReadFinished},  {31'd0, exp_arg_done});
        check({ctx, ".success"},    {31'd0, io_ReadSuccess},           {31'd0, exp_ok});
        check({ctx, ".state"},      {29'd0, io____state},              {29'd0, exp_state()});
        check({ctx, ".pulses"},     pulse_cnt,                         exp_pulses);
        check({ctx, ".wide_pulse"}, wide_cnt,                          0);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        wait_cyc(6);
    endtask

    task automatic set_cs(input logic v);
        io_CS = v;
        wait_cyc(5);
        if (v) begin
            exp_bits = 0;
            frame_q.delete();
        end
    endtask

    task automatic do_reset();
        io_SCK = 1'b0;
        reset  = 1'b1;
        wait_cyc(3);
        reset  = 1'b0;
        model_reset();
        wait_cyc(2);
    endtask

    task automatic send_frame(input logic [5:0] cmd, input logic [31:0] arg, input logic [7:0] crc_xor);
        logic [7:0] crc_byte;
        crc_byte = {crc_ref({2'b01, cmd, arg}), 1'b1} ^ crc_xor;
        send_byte({2'b01, cmd});
        for (int i = 3; i >= 0; i--) send_byte(arg[i*8 +: 8]);
        send_byte(crc_byte);
    endtask

    logic [7:0] rb;

    initial begin
        io_CS = 1'b1; io_SCK = 1'b0; io_DI = 1'b1; reset = 1'b1;
        model_reset();
        do_reset();
        check_outputs("reset");

        for (int i = 0; i < 16; i++) send_bit(1'b1);
        wait_cyc(6);
        check_outputs("cs_high_idle");

        set_cs(1'b0);
        send_byte(8'hFF);
        check_outputs("filler");
        send_byte(8'h40);
        check_outputs("cmd0_cmdbyte");
        for (int i = 0; i < 4; i++) send_byte(8'h00);
        check_outputs("cmd0_args");
        send_byte(8'h95);
        check_outputs("cmd0_crc");
        check("cmd0_literal_ok", {31'd0, io_ReadSuccess}, 32'd1);

        send_byte(8'h48); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h01); send_byte(8'hAA); send_byte(8'h87);
        check_outputs("cmd8");
        check("cmd8_literal_arg", io_CommandArgument, 32'h000001AA);

        send_frame(6'h3B, 32'h0001F791, 8'h02);
        check_outputs("bad_crc");

        send_byte(8'h40); for (int i = 0; i < 4; i++) send_byte(8'h00);
        send_byte(8'h94);
        check_outputs("end_bit0");

        send_byte(8'h40); send_byte(8'h00); send_byte(8'h00);
        check_outputs("before_abort");
        set_cs(1'b1);
        check_outputs("abort");
        set_cs(1'b0);
        send_frame(6'h00, 32'h0, 8'h00);
        check_outputs("after_abort");

        send_byte(8'h51); send_byte(8'h12);
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        set_cs(1'b1);
        set_cs(1'b0);
        send_frame(6'h11, 32'hDEADBEEF, 8'h00);
        check_outputs("partial_abort");

        send_byte(8'h4C); send_byte(8'h01);
        do_reset();
        check_outputs("midframe_reset");
        set_cs(1'b0);

        for (int it = 0; it < 24; it++) begin
            case ($urandom_range(0, 5))
                0, 1, 2: send_frame(6'($urandom_range(0, 63)), $urandom(), 8'h00);
                3: send_frame(6'($urandom_range(0, 63)), $urandom(), 8'(1 << $urandom_range(0, 7)));
                4: begin
                    rb = 8'($urandom());
                    if (rb[7:6] == 2'b01) rb[7] = 1'b1;
                    send_byte(rb);
                end
                default: begin
                    send_byte({2'b01, 6'($urandom_range(0, 63))});
                    for (int k = $urandom_range(0, 3); k > 0; k--) send_byte(8'($urandom()));
                    for (int k = $urandom_range(0, 7); k > 0; k--) send_bit(1'($urandom()));
                    set_cs(1'b1);
                    set_cs(1'b0);
                end
            endcase
            check_outputs($sformatf("rand%0d", it));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
